// File: rtl/lstm_pkg.sv
// -----------------------------------------------------------------------------
// lstm_pkg
// Shared definitions for the LSTM block-RAM arbiter slice.
//   - calc_addr_width / calc_id_width : index-width helpers used to size the
//     address and requester-ID fields from DEPTH and NUM_REQ.
//   - LSTM_DEF_* : default geometry of the arbiter (32-bit data, 256 words,
//     4 requesters per port).
//   - lstm_rsp_t : read-response bundle (valid, id, data) at default geometry.
// -----------------------------------------------------------------------------
package lstm_pkg;

  function automatic int calc_addr_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int calc_id_width(input int num_req);
    return $clog2(num_req);
  endfunction

  localparam int LSTM_DEF_WIDTH    = 32;
  localparam int LSTM_DEF_DEPTH    = 256;
  localparam int LSTM_DEF_NUM_REQ  = 4;
  localparam int LSTM_DEF_ID_WIDTH = calc_id_width(LSTM_DEF_NUM_REQ);

  typedef struct packed {
    logic                         valid;
    logic [LSTM_DEF_ID_WIDTH-1:0] id;
    logic [LSTM_DEF_WIDTH-1:0]    data;
  } lstm_rsp_t;

endpackage

// File: rtl/lstm_rr_arbiter.sv
// -----------------------------------------------------------------------------
// lstm_rr_arbiter
// Single-port round-robin arbiter. The winner is the first asserted request
// found searching upward from the priority pointer, wrapping modulo NUM_REQ.
// After a grant to requester k the pointer moves to (k+1) mod NUM_REQ; with
// no request it holds. Grants are combinational and forced low in reset.
//
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   i_req      : per-requester request vector
//   o_gnt      : one-hot grant (same cycle as request)
//   o_gnt_id   : encoded winner index (valid only when o_valid)
//   o_valid    : a grant is issued this cycle
// -----------------------------------------------------------------------------
module lstm_rr_arbiter
  import lstm_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  localparam int ID_WIDTH = calc_id_width(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REQ-1:0]  i_req,
  output logic [NUM_REQ-1:0]  o_gnt,
  output logic [ID_WIDTH-1:0] o_gnt_id,
  output logic                o_valid
);

  logic [ID_WIDTH-1:0] r_ptr;
  logic [ID_WIDTH-1:0] w_idx;
  logic                w_found;

  // Rotating priority search starting at the pointer.
  always_comb begin
    int k;
    // NOTE: every variable written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_found = 1'b0;
    w_idx   = '0;
    k       = 0;
    // NOTE: combinational blocks use blocking assignments so later statements
    // see the values just computed (w_found gates later iterations).
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(r_ptr) + i) % NUM_REQ;
      if (!w_found && i_req[ID_WIDTH'(k)]) begin
        w_found = 1'b1;
        w_idx   = ID_WIDTH'(k);
      end
    end
  end

  // Reset masks the grant so nothing reaches the RAM while rst_n is low.
  assign o_valid  = w_found && rst_n;
  assign o_gnt    = o_valid ? (NUM_REQ'(1) << w_idx) : '0;
  assign o_gnt_id = w_idx;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= (w_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
    end
  end

endmodule

// File: rtl/lstm_bram_arbiter.sv
// -----------------------------------------------------------------------------
// lstm_bram_arbiter
// Shares one simple dual-port block RAM (one write port, one read port)
// between NUM_REQ requesters. Write and read ports are arbitrated
// independently by two round-robin arbiters. Read data returns one cycle
// after the grant, tagged with the requester ID.
//
// Optional feature (compile-time macro LSTM_BRAM_ARB_RAW_BYPASS_EN):
//   when defined, a same-cycle write and read to the same address returns the
//   freshly written data on the next cycle instead of the RAM's old contents.
//   When undefined, rsp_data is ram_dob (old-data semantics), no extra flops.
//
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   wr_req/wr_addr/wr_data     : packed write requests (slice i = requester i)
//   wr_gnt                     : one-hot write grant, same cycle
//   rd_req/rd_addr             : packed read requests
//   rd_gnt                     : one-hot read grant, same cycle
//   rsp_valid/rsp_id/rsp_data  : read response, one cycle after rd grant
//   ram_ena/ram_wea/ram_addra/ram_dia : RAM write port
//   ram_enb/ram_addrb          : RAM read port
//   ram_dob                    : RAM registered read data
// -----------------------------------------------------------------------------
module lstm_bram_arbiter
  import lstm_pkg::*;
#(
  parameter  int WIDTH      = LSTM_DEF_WIDTH,
  parameter  int DEPTH      = LSTM_DEF_DEPTH,
  parameter  int NUM_REQ    = LSTM_DEF_NUM_REQ,
  localparam int ADDR_WIDTH = calc_addr_width(DEPTH),
  localparam int ID_WIDTH   = calc_id_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            wr_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_REQ*WIDTH-1:0]      wr_data,
  output logic [NUM_REQ-1:0]            wr_gnt,
  input  logic [NUM_REQ-1:0]            rd_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_REQ-1:0]            rd_gnt,
  output logic                          rsp_valid,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [WIDTH-1:0]              rsp_data,
  output logic                          ram_ena,
  output logic                          ram_wea,
  output logic [ADDR_WIDTH-1:0]         ram_addra,
  output logic [WIDTH-1:0]              ram_dia,
  output logic                          ram_enb,
  output logic [ADDR_WIDTH-1:0]         ram_addrb,
  input  logic [WIDTH-1:0]              ram_dob
);

  logic [ID_WIDTH-1:0] w_wr_id;
  logic [ID_WIDTH-1:0] w_rd_id;
  logic                w_wr_valid;
  logic                w_rd_valid;
  logic                r_rsp_valid;
  logic [ID_WIDTH-1:0] r_rsp_id;

  lstm_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (wr_req),
    .o_gnt    (wr_gnt),
    .o_gnt_id (w_wr_id),
    .o_valid  (w_wr_valid)
  );

  lstm_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (rd_req),
    .o_gnt    (rd_gnt),
    .o_gnt_id (w_rd_id),
    .o_valid  (w_rd_valid)
  );

  // Winner slice selection; constant slice bases keep the mux simple.
  always_comb begin
    ram_addra = '0;
    ram_dia   = '0;
    ram_addrb = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_wr_id == ID_WIDTH'(i)) begin
        ram_addra = wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        ram_dia   = wr_data[i*WIDTH +: WIDTH];
      end
      if (w_rd_id == ID_WIDTH'(i)) begin
        ram_addrb = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Enables equal "any request", already masked by reset inside the arbiters.
  assign ram_ena = w_wr_valid;
  assign ram_wea = w_wr_valid;
  assign ram_enb = w_rd_valid;

  // Response tag travels alongside the RAM's one-cycle read latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
    end else begin
      r_rsp_valid <= w_rd_valid;
      r_rsp_id    <= w_rd_id;
    end
  end

  // A read granted just before reset asserts would otherwise surface during
  // the first reset cycle; masking with rst_n drops it.
  assign rsp_valid = r_rsp_valid && rst_n;
  assign rsp_id    = r_rsp_id;

`ifdef LSTM_BRAM_ARB_RAW_BYPASS_EN
  logic             r_hit;
  logic [WIDTH-1:0] r_byp_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hit <= 1'b0;
    end else begin
      r_hit <= w_wr_valid && w_rd_valid && (ram_addra == ram_addrb);
    end
  end

  // NOTE: the data register has no reset; it is only observed when r_hit is
  // set, and r_hit is reset, so resetting the data would cost logic for nothing.
  always_ff @(posedge clk) begin
    r_byp_data <= ram_dia;
  end

  assign rsp_data = r_hit ? r_byp_data : ram_dob;
`else
  assign rsp_data = ram_dob;
`endif

endmodule

// File: tb/tb_lstm_bram_arbiter.sv
module tb_lstm_bram_arbiter;
  import lstm_pkg::*;

  localparam int W  = 32;
  localparam int AW = 8;
  localparam int N  = 4;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    wr_req;
  logic [N*AW-1:0] wr_addr;
  logic [N*W-1:0]  wr_data;
  logic [N-1:0]    wr_gnt;
  logic [N-1:0]    rd_req;
  logic [N*AW-1:0] rd_addr;
  logic [N-1:0]    rd_gnt;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [W-1:0]    rsp_data;
  logic            ram_ena;
  logic            ram_wea;
  logic [AW-1:0]   ram_addra;
  logic [W-1:0]    ram_dia;
  logic            ram_enb;
  logic [AW-1:0]   ram_addrb;
  logic [W-1:0]    ram_dob;

  lstm_bram_arbiter #(.WIDTH(W), .DEPTH(256), .NUM_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_gnt    (wr_gnt),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_gnt    (rd_gnt),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .ram_ena   (ram_ena),
    .ram_wea   (ram_wea),
    .ram_addra (ram_addra),
    .ram_dia   (ram_dia),
    .ram_enb   (ram_enb),
    .ram_addrb (ram_addrb),
    .ram_dob   (ram_dob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple dual-port RAM with registered, read-before-write output.
  logic [W-1:0] tb_mem [256];
  always @(posedge clk) begin
    if (ram_ena && ram_wea) tb_mem[ram_addra] <= ram_dia;
    if (ram_enb) ram_dob <= tb_mem[ram_addrb];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state.
  typedef struct {
    int        due;
    lstm_rsp_t rsp;
  } exp_t;
  exp_t          sb[$];
  int            wr_ptr_m = 0;
  int            rd_ptr_m = 0;
  logic [W-1:0]  mem_m [16];
  int            wa [N];
  int            ra [N];
  logic [W-1:0]  wd [N];
  logic [N-1:0]  last_wreq = '0, last_wgnt = '0, last_rreq = '0, last_rgnt = '0;

  function automatic int pick(input logic [N-1:0] req, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (req[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  // One clock cycle: drive at negedge, check grants, predict the response.
  task automatic drive_cycle(input logic rst, input logic [N-1:0] wq, input logic [N-1:0] rq);
    int w, r;
    logic [N-1:0] ew, er;
    lstm_rsp_t    rsp;
    @(negedge clk);
    rst_n = rst;
    for (int i = 0; i < N; i++) begin
      wr_addr[i*AW +: AW] = AW'(wa[i]);
      wr_data[i*W +: W]   = wd[i];
      rd_addr[i*AW +: AW] = AW'(ra[i]);
    end
    wr_req = wq;
    rd_req = rq;
    #1;
    w  = rst ? pick(wq, wr_ptr_m) : -1;
    r  = rst ? pick(rq, rd_ptr_m) : -1;
    ew = (w >= 0) ? N'(1) << w : '0;
    er = (r >= 0) ? N'(1) << r : '0;
    check("wr_gnt", wr_gnt, ew);
    check("rd_gnt", rd_gnt, er);
    check("ram_ena", ram_ena, w >= 0);
    check("ram_wea", ram_wea, w >= 0);
    check("ram_enb", ram_enb, r >= 0);
    if (w >= 0) begin
      check("ram_addra", ram_addra, wa[w]);
      check("ram_dia", ram_dia, wd[w]);
    end
    if (r >= 0) begin
      check("ram_addrb", ram_addrb, ra[r]);
      rsp.valid = 1'b1;
      rsp.id    = 2'(r);
      rsp.data  = mem_m[ra[r]];
`ifdef LSTM_BRAM_ARB_RAW_BYPASS_EN
      if (w >= 0 && wa[w] == ra[r]) rsp.data = wd[w];
`endif
      sb.push_back('{due: cyc + 1, rsp: rsp});
    end
    if (!rst) begin
      check("rsp_valid_in_reset", rsp_valid, 1'b0);
      sb.delete();
      wr_ptr_m = 0;
      rd_ptr_m = 0;
    end
    if (w >= 0) begin
      mem_m[wa[w]] = wd[w];
      wr_ptr_m = (w + 1) % N;
    end
    if (r >= 0) rd_ptr_m = (r + 1) % N;
    last_wreq = wq; last_wgnt = ew;
    last_rreq = rq; last_rgnt = er;
  endtask

  // Monitor: pops the scoreboard whenever a response is due or presented.
  always @(posedge clk) begin
    #1;
    while (sb.size() > 0 && sb[0].due < cyc) begin
      check("rsp_missing", 1'b0, 1'b1);
      void'(sb.pop_front());
    end
    if (rsp_valid) begin
      if (sb.size() == 0 || sb[0].due != cyc) begin
        check("rsp_unexpected", rsp_valid, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_id", rsp_id, e.rsp.id);
        check("rsp_data", rsp_data, e.rsp.data);
      end
    end else if (sb.size() > 0 && sb[0].due == cyc) begin
      check("rsp_valid", rsp_valid, 1'b1);
      void'(sb.pop_front());
    end
  end

  initial begin
    logic [N-1:0] wq, rq;
    logic         rs;
    rst_n = 1'b0; wr_req = '0; rd_req = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    for (int i = 0; i < N; i++) begin
      wa[i] = i; ra[i] = i; wd[i] = 32'(i);
    end

    // Reset with requests asserted: nothing may be granted.
    repeat (3) drive_cycle(1'b0, 4'b1111, 4'b1111);
    drive_cycle(1'b1, 4'b0000, 4'b0000);
    check("rsp_id_after_reset", rsp_id, 2'd0);
    check("rsp_valid_after_reset", rsp_valid, 1'b0);

    // Initialise the 16 addresses used by the bench.
    for (int a = 0; a < 16; a++) begin
      wa[a % N] = a;
      wd[a % N] = 32'hA500_0000 | 32'(a);
      drive_cycle(1'b1, N'(1) << (a % N), 4'b0000);
    end

    // All four readers held: grants 0,1,2,3 and back-to-back responses.
    for (int i = 0; i < N; i++) ra[i] = 3 * i + 1;
    repeat (4) drive_cycle(1'b1, 4'b0000, 4'b1111);

    // Write then read the following cycle.
    wa[2] = 5; wd[2] = 32'hDEADBEEF;
    drive_cycle(1'b1, 4'b0100, 4'b0000);
    ra[1] = 5;
    drive_cycle(1'b1, 4'b0000, 4'b0010);

    // Same-cycle write/read collision on address 7.
    wa[0] = 7; wd[0] = 32'h11;
    drive_cycle(1'b1, 4'b0001, 4'b0000);
    wa[3] = 7; wd[3] = 32'h22; ra[2] = 7;
    drive_cycle(1'b1, 4'b1000, 4'b0100);

    // Wrap-around: reset, 1000 at ptr 0, then 1001 goes to 0, then 1111 to 1.
    drive_cycle(1'b0, 4'b0000, 4'b0000);
    drive_cycle(1'b1, 4'b0000, 4'b1000);
    drive_cycle(1'b1, 4'b0000, 4'b1001);
    drive_cycle(1'b1, 4'b0000, 4'b1111);

    // Read granted, then reset next cycle: response dropped.
    drive_cycle(1'b1, 4'b0000, 4'b0100);
    drive_cycle(1'b0, 4'b1111, 4'b1111);
    drive_cycle(1'b0, 4'b1111, 4'b1111);
    drive_cycle(1'b1, 4'b0000, 4'b1111);

    // Idle: enables stay low and pointers hold.
    drive_cycle(1'b1, 4'b0110, 4'b0000);
    repeat (10) drive_cycle(1'b1, 4'b0000, 4'b0000);
    check("idle_rsp_valid", rsp_valid, 1'b0);
    drive_cycle(1'b1, 4'b1111, 4'b1111);

    // Randomized traffic honouring the hold-until-granted rule.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (last_wreq[i] && !last_wgnt[i]) begin
          wq[i] = 1'b1;
        end else begin
          wq[i] = ($urandom_range(0, 2) == 0);
          wa[i] = $urandom_range(0, 15);
          wd[i] = $urandom;
        end
        if (last_rreq[i] && !last_rgnt[i]) begin
          rq[i] = 1'b1;
        end else begin
          rq[i] = ($urandom_range(0, 1) == 0);
          ra[i] = $urandom_range(0, 15);
        end
      end
      rs = ($urandom_range(0, 60) != 0);
      drive_cycle(rs, wq, rq);
    end

    repeat (3) drive_cycle(1'b1, 4'b0000, 4'b0000);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
